// File: rtl/memory.sv
// rtl/memory.sv - rv32 memory-access stage (define MEMORY_MISALIGN_TRAP_EN to trap misaligned H/W accesses)
package core;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {NULL = 2'd0, REGISTER = 2'd1, LOAD = 2'd2, STORE = 2'd3} op_t;
    typedef enum logic [1:0] {B = 2'd0, H = 2'd1, W = 2'd2} size_t;

    typedef struct packed {
        op_t   op;
        size_t size;
        logic  uns;
    } mm_ctrl_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs2;
    } mm_data_t;

    typedef struct packed {
        mm_ctrl_t ctrl;
        mm_data_t data;
    } mm_t;

    typedef struct packed {
        op_t op;
    } wb_ctrl_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
    } wb_data_t;

    typedef struct packed {
        wb_ctrl_t ctrl;
        wb_data_t data;
    } wb_t;
endpackage

module memory
    import core::*;
#(
    parameter int XLEN = 32
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            s_tvalid,
    output logic            s_tready,
    input  mm_t             s_tdata,
    output logic            m_tvalid,
    input  logic            m_tready,
    output wb_t             m_tdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_strb,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

    state_t          state_q, state_d, accept_state;
    mm_t             tok;
    wb_t             wb_q;
    logic            mis_q;
    logic            accept;
    logic            is_mem;
    logic            mis_in;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] load_val;

    assign is_mem = (s_tdata.ctrl.op == LOAD) || (s_tdata.ctrl.op == STORE);
    assign accept = s_tvalid && s_tready;

    always_comb begin
        mis_in = 1'b0;
`ifdef MEMORY_MISALIGN_TRAP_EN
        mis_in = is_mem &&
                 (((s_tdata.ctrl.size == H) && s_tdata.data.alu[0]) ||
                  ((s_tdata.ctrl.size == W) && (s_tdata.data.alu[1:0] != 2'b00)));
`endif
        accept_state = (is_mem && !mis_in) ? REQ : OUT;
    end

    // Lane extraction for loads; low address bits beyond the access size are ignored
    always_comb begin
        lane_b   = dmem_rdata[{tok.data.alu[1:0], 3'b000} +: 8];
        lane_h   = dmem_rdata[{tok.data.alu[1], 4'b0000} +: 16];
        load_val = dmem_rdata;
        case (tok.ctrl.size)
            B:       load_val = {{(XLEN-8){lane_b[7] & ~tok.ctrl.uns}}, lane_b};
            H:       load_val = {{(XLEN-16){lane_h[15] & ~tok.ctrl.uns}}, lane_h};
            default: load_val = dmem_rdata;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = accept_state;
            REQ:  if (dmem_gnt) state_d = (tok.ctrl.op == STORE) ? OUT : RESP;
            RESP: if (dmem_rvalid) state_d = OUT;
            OUT:  if (m_tready) state_d = accept ? accept_state : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_tready   = (state_q == IDLE) || ((state_q == OUT) && m_tready);
        m_tvalid   = (state_q == OUT);
        m_tdata    = wb_q;
        misaligned = mis_q;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_strb  = 4'b0000;
        if (state_q == REQ) begin
            dmem_req  = 1'b1;
            dmem_we   = (tok.ctrl.op == STORE);
            dmem_addr = {tok.data.alu[XLEN-1:2], 2'b00};
            case (tok.ctrl.size)
                B: begin
                    dmem_strb  = 4'b0001 << tok.data.alu[1:0];
                    dmem_wdata = {(XLEN/8){tok.data.rs2[7:0]}};
                end
                H: begin
                    dmem_strb  = 4'b0011 << {tok.data.alu[1], 1'b0};
                    dmem_wdata = {(XLEN/16){tok.data.rs2[15:0]}};
                end
                default: begin
                    dmem_strb  = 4'b1111;
                    dmem_wdata = tok.data.rs2;
                end
            endcase
        end
    end

    // Memory ops start out as NULL write-backs; only a completed load upgrades to REGISTER
    always_ff @(posedge aclk) begin
        if (areset) begin
            tok   <= '0;
            wb_q  <= '0;
            mis_q <= 1'b0;
        end else begin
            mis_q <= accept && mis_in;
            if (accept) begin
                tok              <= s_tdata;
                wb_q.ctrl.op     <= is_mem ? NULL : s_tdata.ctrl.op;
                wb_q.data.rd     <= s_tdata.data.rd;
                wb_q.data.val    <= s_tdata.data.alu;
            end else if ((state_q == RESP) && dmem_rvalid) begin
                wb_q.ctrl.op  <= REGISTER;
                wb_q.data.val <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - scoreboard testbench for the memory-access stage
module tb_memory;
    import core::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_tvalid, s_tready;
    mm_t         s_tdata;
    logic        m_tvalid, m_tready;
    wb_t         m_tdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_strb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        misaligned;

    int  errors = 0;
    int  checks = 0;
    wb_t sb[$];
    wb_t mon_e;

    always #5 aclk = ~aclk;

    memory #(.XLEN(32)) dut (
        .aclk(aclk), .areset(areset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_strb(dmem_strb), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .misaligned(misaligned)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mm_t mk(input op_t op, input size_t sz, input logic uns,
                               input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rs2);
        mm_t t;
        t = '0;
        t.ctrl.op   = op;
        t.ctrl.size = sz;
        t.ctrl.uns  = uns;
        t.data.rd   = rd;
        t.data.alu  = alu;
        t.data.rs2  = rs2;
        return t;
    endfunction

    function automatic wb_t mkwb(input op_t op, input logic [4:0] rd, input logic [31:0] val);
        wb_t w;
        w.ctrl.op  = op;
        w.data.rd  = rd;
        w.data.val = val;
        return w;
    endfunction

    always @(negedge aclk) begin
        if (!areset && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_op", m_tdata.ctrl.op, mon_e.ctrl.op);
                check("wb_rd", m_tdata.data.rd, mon_e.data.rd);
                if (mon_e.ctrl.op == REGISTER) check("wb_val", m_tdata.data.val, mon_e.data.val);
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Drives one load/store token through request, grant and (for loads) response; ends on the negedge after completion
    task automatic mem_txn(input mm_t t, input int gw, input int rw, input logic [31:0] rdata,
                           input logic [31:0] eaddr, input logic [3:0] estrb, input logic [31:0] ewdata,
                           input wb_t ewb);
        logic st;
        st = (t.ctrl.op == STORE);
        sb.push_back(ewb);
        s_tdata  = t;
        s_tvalid = 1'b1;
        @(negedge aclk);
        check("acc_ready", s_tready, 1);
        step();
        s_tvalid = 1'b0;
        for (int k = 0; k <= gw; k++) begin
            dmem_gnt    = (k == gw);
            dmem_rvalid = 1'b1;
            dmem_rdata  = 32'h5A5A_A5A5;
            @(negedge aclk);
            check("req", dmem_req, 1);
            check("req_addr", dmem_addr, eaddr);
            check("req_we", dmem_we, st);
            check("req_valid_low", m_tvalid, 0);
            if (st) begin
                check("req_strb", dmem_strb, estrb);
                check("req_wdata", dmem_wdata, ewdata);
            end
            step();
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (!st) begin
            @(negedge aclk);
            check("resp_req_low", dmem_req, 0);
            check("resp_valid_low", m_tvalid, 0);
            for (int k = 1; k < rw; k++) step();
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            step();
            dmem_rvalid = 1'b0;
        end
        @(negedge aclk);
        check("out_valid", m_tvalid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        mm_t t;
        logic [31:0] v;
        areset      = 1'b1;
        s_tvalid    = 1'b0;
        s_tdata     = '0;
        m_tready    = 1'b1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        step();
        step();
        @(negedge aclk);
        check("rst_s_tready", s_tready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_op", m_tdata.ctrl.op, NULL);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_strb", dmem_strb, 0);
        check("rst_mis", misaligned, 0);
        step();
        areset = 1'b0;

        // Back-to-back pass-through tokens, one per cycle
        for (int i = 0; i < 5; i++) begin
            v = (i == 0) ? 32'h1234_5678 : $urandom;
            t = mk((i == 3) ? NULL : REGISTER, W, 1'b0, (i == 0) ? 5'd5 : ((i == 2) ? 5'd0 : 5'(i * 3)), v, 32'h0);
            s_tdata  = t;
            s_tvalid = 1'b1;
            sb.push_back(mkwb(t.ctrl.op, t.data.rd, v));
            @(negedge aclk);
            check("pt_ready", s_tready, 1);
            if (i > 0) check("pt_valid", m_tvalid, 1);
            step();
        end
        s_tvalid = 1'b0;
        @(negedge aclk);
        check("pt_valid_last", m_tvalid, 1);
        step();
        @(negedge aclk);
        check("pt_drain", m_tvalid, 0);
        step();

        mem_txn(mk(LOAD, B, 1'b0, 5'd7, 32'h0000_1003, 32'h0), 2, 3, 32'h8012_3456,
                32'h0000_1000, 4'h0, 32'h0, mkwb(REGISTER, 5'd7, 32'hFFFF_FF80));
        step();
        mem_txn(mk(LOAD, B, 1'b1, 5'd8, 32'h0000_1003, 32'h0), 2, 3, 32'h8012_3456,
                32'h0000_1000, 4'h0, 32'h0, mkwb(REGISTER, 5'd8, 32'h0000_0080));
        step();
        mem_txn(mk(LOAD, H, 1'b0, 5'd10, 32'h0000_1002, 32'h0), 0, 1, 32'h8001_1234,
                32'h0000_1000, 4'h0, 32'h0, mkwb(REGISTER, 5'd10, 32'hFFFF_8001));
        step();
        mem_txn(mk(LOAD, H, 1'b1, 5'd11, 32'h0000_1000, 32'h0), 1, 2, 32'h8001_9234,
                32'h0000_1000, 4'h0, 32'h0, mkwb(REGISTER, 5'd11, 32'h0000_9234));
        step();
        mem_txn(mk(STORE, H, 1'b0, 5'd9, 32'h0000_2002, 32'hDEAD_BEEF), 0, 0, 32'h0,
                32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, mkwb(NULL, 5'd9, 32'h0));
        step();
        mem_txn(mk(STORE, B, 1'b0, 5'd12, 32'h0000_2001, 32'h1234_5678), 1, 0, 32'h0,
                32'h0000_2000, 4'b0010, 32'h7878_7878, mkwb(NULL, 5'd12, 32'h0));
        step();
        mem_txn(mk(STORE, W, 1'b0, 5'd13, 32'h0000_2004, 32'hA5A5_0F0F), 2, 0, 32'h0,
                32'h0000_2004, 4'b1111, 32'hA5A5_0F0F, mkwb(NULL, 5'd13, 32'h0));
        step();

        // Output backpressure on a load result, with the next token waiting
        m_tready = 1'b0;
        mem_txn(mk(LOAD, W, 1'b0, 5'd3, 32'h0000_4000, 32'h0), 0, 1, 32'h1122_3344,
                32'h0000_4000, 4'h0, 32'h0, mkwb(REGISTER, 5'd3, 32'h1122_3344));
        step();
        s_tdata  = mk(REGISTER, W, 1'b0, 5'd14, 32'h0BAD_F00D, 32'h0);
        s_tvalid = 1'b1;
        sb.push_back(mkwb(REGISTER, 5'd14, 32'h0BAD_F00D));
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            check("stall_valid", m_tvalid, 1);
            check("stall_val", m_tdata.data.val, 32'h1122_3344);
            check("stall_rd", m_tdata.data.rd, 3);
            check("stall_ready", s_tready, 0);
            step();
        end
        m_tready = 1'b1;
        @(negedge aclk);
        check("release_ready", s_tready, 1);
        step();
        s_tvalid = 1'b0;
        @(negedge aclk);
        check("release_next_valid", m_tvalid, 1);
        step();

        t = mk(LOAD, W, 1'b0, 5'd4, 32'h0000_3001, 32'h0);
`ifdef MEMORY_MISALIGN_TRAP_EN
        sb.push_back(mkwb(NULL, 5'd4, 32'h0));
        s_tdata  = t;
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        @(negedge aclk);
        check("mis_pulse", misaligned, 1);
        check("mis_no_req", dmem_req, 0);
        check("mis_valid", m_tvalid, 1);
        step();
        @(negedge aclk);
        check("mis_pulse_end", misaligned, 0);
        check("mis_no_req2", dmem_req, 0);
        step();
`else
        mem_txn(t, 1, 2, 32'hCAFE_F00D, 32'h0000_3000, 4'h0, 32'h0, mkwb(REGISTER, 5'd4, 32'hCAFE_F00D));
        check("mis_tied", misaligned, 0);
        step();
`endif

        // Reset while waiting for a load response, then a late response
        s_tdata  = mk(LOAD, W, 1'b0, 5'd15, 32'h0000_5000, 32'h0);
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        areset   = 1'b1;
        step();
        areset      = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        step();
        dmem_rvalid = 1'b0;
        @(negedge aclk);
        check("rr_m_tvalid", m_tvalid, 0);
        check("rr_req", dmem_req, 0);
        check("rr_we", dmem_we, 0);
        check("rr_strb", dmem_strb, 0);
        check("rr_s_tready", s_tready, 1);
        check("rr_op", m_tdata.ctrl.op, NULL);
        check("rr_mis", misaligned, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge aclk);
            check("rr_quiet", m_tvalid, 0);
        end
        step();

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory.md
# memory

Memory-access stage of the rv32 pipeline: consumes `mm_t` tokens from the execute stage over a valid/ready stream, performs loads and stores on the data-memory bus, and emits `wb_t` tokens to write-back. One token is in flight at a time. Non-memory ops pass through with one register stage.

## Interface
- `XLEN`, 32: data/address width.
- `aclk` in 1: clock.
- `areset` in 1: synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `s_tvalid` in 1, `s_tready` out 1, `s_tdata` in `core::mm_t`: fields used are `ctrl.op` (NULL/REGISTER/LOAD/STORE), `ctrl.size` (B/H/W), `ctrl.uns`, `data.rd[4:0]`, `data.alu` (result or address), `data.rs2` (store data).
- `m_tvalid` out 1, `m_tready` in 1, `m_tdata` out `core::wb_t`: `ctrl.op` (NULL/REGISTER), `data.rd`, `data.val`.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out XLEN (word-aligned), `dmem_wdata` out XLEN, `dmem_strb` out 4: request held until `dmem_gnt`.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1, `dmem_rdata` in XLEN: load response, ≥1 cycle after grant.
- `misaligned` out 1: one-cycle fault pulse (macro-dependent).

## Operation
- FSM states: IDLE, REQ, RESP, OUT.
- IDLE: `s_tready = ~m_tvalid | m_tready`. On accept:
  - NULL/REGISTER → OUT, `wb.op = ctrl.op`, `wb.val = alu`, `wb.rd = rd`.
  - LOAD/STORE → REQ, latch token.
- REQ: `dmem_req=1`, `dmem_addr = {alu[XLEN-1:2],2'b00}`, `dmem_we = (op==STORE)`. On `dmem_gnt`: STORE → OUT with `wb.op = NULL`; LOAD → RESP.
- RESP: on `dmem_rvalid`, extract lane by `alu[1:0]`: B → byte `alu[1:0]`, H → half `alu[1]`, W → full word; sign-extend unless `uns`. → OUT with `wb.op = REGISTER`.
- OUT: `m_tvalid=1`, `m_tdata` stable until `m_tready`. On handshake → IDLE; a new `s_tvalid` may be accepted in the same cycle (`s_tready` high via `m_tready`), going directly to its next state.
- Store lanes: B → `strb = 4'b0001 << alu[1:0]`, `wdata = {4{rs2[7:0]}}`. H → `strb = 4'b0011 << {alu[1],1'b0}`, `wdata = {2{rs2[15:0]}}`. W → `strb = 4'b1111`, `wdata = rs2`.
- `rd == 0` with REGISTER: forwarded unchanged; write-back discards it.
- `dmem_strb`/`dmem_wdata` are don't-care when `dmem_we=0`. They are driven 0 outside REQ.

## Timing
- Reset values: state IDLE, `m_tvalid=0`, `m_tdata` op NULL, `dmem_req=0`, `dmem_we=0`, `dmem_strb=0`, `misaligned=0`, `s_tready=1`.
- Pass-through latency: accept at cycle N → `m_tvalid` at N+1.
- Store: `dmem_req` at N+1; grant at cycle G → `m_tvalid` at G+1.
- Load: `rvalid` at cycle R → `m_tvalid` with data at R+1.
- `dmem_req` and its address, data and strobe stay constant until grant.
- `dmem_rvalid` outside RESP is ignored.
- Output backpressure: `s_tready=0` while `m_tvalid & ~m_tready`. No token is dropped or duplicated.
- Reset mid-operation (REQ/RESP/OUT): next cycle IDLE. Outstanding request is abandoned; a late `rvalid` is ignored. The memory side is required to be reset together with this block.

## Configuration
- `MEMORY_MISALIGN_TRAP_EN` defined:
  - Condition: H with `alu[0]=1`, or W with `alu[1:0]≠0`.
  - On accept, no bus request is issued.
  - `misaligned` pulses for one cycle (accept cycle +1).
  - Token goes to OUT with `wb.op = NULL`.
- Undefined:
  - `misaligned` is tied to 0.
  - Low address bits beyond the access size are ignored: H uses `alu[1]`, W ignores `alu[1:0]`.
  - The access proceeds normally.

## Test plan
- REGISTER, `rd=5`, `alu=0x1234_5678`, `m_tready=1` → one cycle later `m_tvalid=1`, `{REGISTER,5,0x12345678}`. Back-to-back tokens sustain 1/cycle.
- LOAD B signed at `0x1003`, `rdata=0x80xx_xxxx`, grant after 2 wait cycles, `rvalid` 3 cycles later → `dmem_addr=0x1000` held through grant; `val=0xFFFF_FF80`. Repeat with `uns=1` → `0x0000_0080`.
- STORE H at `0x2002`, `rs2=0xDEAD_BEEF` → `strb=4'b1100`, `wdata=0xBEEF_BEEF`, `we=1`; output `op=NULL`.
- `m_tready=0` for 4 cycles after a LOAD result → `m_tdata` stable, `s_tready=0`. Release → one handshake, then next token accepted.
- LOAD W at `0x3001`: with macro → no `dmem_req`, `misaligned` pulses once, output `op=NULL`. Without macro → `addr=0x3000`, full word returned.
- Assert `areset` while in RESP, then drive `rvalid` → all outputs return to reset values; no `m_tvalid`.
